// File: rtl/ayatsuki_bus_fabric_pkg.sv
// Shared definitions for the ayatsuki bus fabric: read FSM encoding and default memory map.
package ayatsuki_bus_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } rd_state_e;

    localparam int unsigned MAP_ADDR_W = 32;
    localparam int unsigned MAP_SLOTS  = 4;

    // Slave 0 is memory, slave 1 the uart, slaves 2 and 3 the timers.
    localparam logic [MAP_ADDR_W-1:0] MEM_BASE  = 32'h0000_0000;
    localparam logic [MAP_ADDR_W-1:0] MEM_MASK  = 32'h0000_0E00;
    localparam logic [MAP_ADDR_W-1:0] UART_BASE = 32'h0000_0200;
    localparam logic [MAP_ADDR_W-1:0] UART_MASK = 32'h0000_0FF0;
    localparam logic [MAP_ADDR_W-1:0] TIM0_BASE = 32'h0000_0300;
    localparam logic [MAP_ADDR_W-1:0] TIM0_MASK = 32'h0000_0FF0;
    localparam logic [MAP_ADDR_W-1:0] TIM1_BASE = 32'h0000_0400;
    localparam logic [MAP_ADDR_W-1:0] TIM1_MASK = 32'h0000_0FF0;

    localparam logic [MAP_SLOTS*MAP_ADDR_W-1:0] DEF_SLV_BASE =
        {TIM1_BASE, TIM0_BASE, UART_BASE, MEM_BASE};
    localparam logic [MAP_SLOTS*MAP_ADDR_W-1:0] DEF_SLV_MASK =
        {TIM1_MASK, TIM0_MASK, UART_MASK, MEM_MASK};

    localparam logic [31:0] RD_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/ayatsuki_addr_decode.sv
// Address decoder: maps an address to a one-hot slave hit and its index; lowest index wins on overlap.
module ayatsuki_addr_decode #(
    parameter int unsigned                    NUM_SLV  = 4,
    parameter int unsigned                    ADDR_W   = 32,
    parameter int unsigned                    IDX_W    = 2,
    parameter logic [NUM_SLV*ADDR_W-1:0]      SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0]      SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] hit,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top so the lowest matching region is assigned last.
    always_comb begin
        hit = '0;
        idx = '0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if ((addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                hit = NUM_SLV'(1) << k;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/ayatsuki_bus_fabric.sv
// Single-master bus fabric: zero-latency posted writes, one outstanding read with timeout, error tracking.
module ayatsuki_bus_fabric
    import ayatsuki_bus_fabric_pkg::*;
#(
    parameter int unsigned               NUM_SLV  = 4,
    parameter int unsigned               ADDR_W   = 32,
    parameter int unsigned               DATA_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = (NUM_SLV*ADDR_W)'(DEF_SLV_BASE),
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = (NUM_SLV*ADDR_W)'(DEF_SLV_MASK),
    parameter int unsigned               TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_w_en,
    input  logic [ADDR_W-1:0]         m_w_addr,
    input  logic [DATA_W-1:0]         m_w_data,
    input  logic                      m_r_en,
    input  logic [ADDR_W-1:0]         m_r_addr,
    output logic [DATA_W-1:0]         m_r_data,
    output logic                      m_r_valid,
    output logic                      m_busy,
    output logic                      m_err,
    output logic [NUM_SLV-1:0]        s_w_en,
    output logic [NUM_SLV-1:0]        s_r_en,
    output logic [ADDR_W-1:0]         s_w_addr,
    output logic [ADDR_W-1:0]         s_r_addr,
    output logic [DATA_W-1:0]         s_w_data,
    input  logic [NUM_SLV*DATA_W-1:0] s_r_data,
    input  logic [NUM_SLV-1:0]        s_ready,
    output logic [ADDR_W-1:0]         err_addr,
    output logic [7:0]                err_cnt
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [NUM_SLV-1:0] w_hit, r_hit;
    logic [IDX_W-1:0]   w_idx, r_idx, sel_q, cap_idx;
    logic               w_any, r_any, w_err;
    rd_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, rd_err_addr;
    logic [TMO_W-1:0]   tmo_q;
    logic [NUM_SLV-1:0] s_r_en_c;
    logic               rd_done, rd_err;
    logic [DATA_W-1:0]  rd_word;
    logic [8:0]         cnt_sum;

    ayatsuki_addr_decode #(
        .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
        .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_w_dec (
        .addr(m_w_addr), .hit(w_hit), .idx(w_idx)
    );

    ayatsuki_addr_decode #(
        .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
        .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_r_dec (
        .addr(m_r_addr), .hit(r_hit), .idx(r_idx)
    );

    assign w_any    = |w_hit;
    assign r_any    = |r_hit;
    assign w_err    = m_w_en & ~w_any;
    assign s_w_en   = (m_w_en && w_any && !rst) ? (NUM_SLV'(1) << w_idx) : '0;
    assign s_w_addr = m_w_addr;
    assign s_w_data = m_w_data;
    assign s_r_en   = rst ? '0 : s_r_en_c;
    assign s_r_addr = (state_q == IDLE) ? m_r_addr : addr_q;
    assign m_busy   = (state_q != IDLE);

    // A same-cycle ready in IDLE is taken from the slave being strobed, later ones from the latched slave.
    assign cap_idx     = (state_q == IDLE) ? r_idx : sel_q;
    assign rd_word     = s_r_data[cap_idx*DATA_W +: DATA_W];
    assign rd_err_addr = (state_q == IDLE) ? m_r_addr : addr_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        s_r_en_c = '0;
        rd_done  = 1'b0;
        rd_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_r_en) begin
                    if (r_any) begin
                        s_r_en_c = r_hit;
                        if (s_ready[r_idx]) begin
                            state_d = DONE;
                            rd_done = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        state_d = DONE;
                        rd_done = 1'b1;
                        rd_err  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (s_ready[sel_q]) begin
                    state_d = DONE;
                    rd_done = 1'b1;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    rd_done = 1'b1;
                    rd_err  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous read and write errors count twice.
    assign cnt_sum = {1'b0, err_cnt} + 9'(rd_err) + 9'(w_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            addr_q    <= '0;
            tmo_q     <= '0;
            m_r_valid <= 1'b0;
            m_r_data  <= '0;
            m_err     <= 1'b0;
            err_cnt   <= '0;
            err_addr  <= '0;
        end else begin
            if (state_q == IDLE && m_r_en && r_any) begin
                sel_q  <= r_idx;
                addr_q <= m_r_addr;
            end
            tmo_q     <= (state_q == WAIT) ? tmo_q + TMO_W'(1) : '0;
            m_r_valid <= rd_done;
            if (rd_done) m_r_data <= rd_err ? DATA_W'(RD_ERR_DATA) : rd_word;
            m_err     <= rd_err | w_err;
            err_cnt   <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
            if (rd_err)     err_addr <= rd_err_addr;
            else if (w_err) err_addr <= m_w_addr;
        end
    end

endmodule

// File: tb/tb_ayatsuki_bus_fabric.sv
// Directed bench for ayatsuki_bus_fabric with the default four-slave memory map.
module tb_ayatsuki_bus_fabric;

    localparam int unsigned NUM_SLV = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      m_w_en;
    logic [ADDR_W-1:0]         m_w_addr;
    logic [DATA_W-1:0]         m_w_data;
    logic                      m_r_en;
    logic [ADDR_W-1:0]         m_r_addr;
    logic [DATA_W-1:0]         m_r_data;
    logic                      m_r_valid;
    logic                      m_busy;
    logic                      m_err;
    logic [NUM_SLV-1:0]        s_w_en;
    logic [NUM_SLV-1:0]        s_r_en;
    logic [ADDR_W-1:0]         s_w_addr;
    logic [ADDR_W-1:0]         s_r_addr;
    logic [DATA_W-1:0]         s_w_data;
    logic [NUM_SLV*DATA_W-1:0] s_r_data;
    logic [NUM_SLV-1:0]        s_ready;
    logic [ADDR_W-1:0]         err_addr;
    logic [7:0]                err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ayatsuki_bus_fabric dut (
        .clk(clk), .rst(rst),
        .m_w_en(m_w_en), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
        .m_r_en(m_r_en), .m_r_addr(m_r_addr),
        .m_r_data(m_r_data), .m_r_valid(m_r_valid), .m_busy(m_busy), .m_err(m_err),
        .s_w_en(s_w_en), .s_r_en(s_r_en),
        .s_w_addr(s_w_addr), .s_r_addr(s_r_addr), .s_w_data(s_w_data),
        .s_r_data(s_r_data), .s_ready(s_ready),
        .err_addr(err_addr), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int exp_cnt;

        rst      = 1'b1;
        m_w_en   = 1'b0;
        m_w_addr = '0;
        m_w_data = '0;
        m_r_en   = 1'b0;
        m_r_addr = '0;
        s_ready  = '0;
        s_r_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        tick();
        tick();

        check("rst_valid", 64'(m_r_valid), 64'd0);
        check("rst_busy",  64'(m_busy),    64'd0);
        check("rst_err",   64'(m_err),     64'd0);
        check("rst_cnt",   64'(err_cnt),   64'd0);
        check("rst_eaddr", 64'(err_addr),  64'd0);
        check("rst_rdata", 64'(m_r_data),  64'd0);
        rst = 1'b0;

        // Read 0x304 from slave 2, ready one cycle after the strobe.
        m_r_en = 1'b1; m_r_addr = 32'h304;
        #1 check("rd2_sren", 64'(s_r_en), 64'b0100);
        tick();
        m_r_en = 1'b0;
        #1 check("rd2_sren_off", 64'(s_r_en), 64'd0);
        check("rd2_busy", 64'(m_busy), 64'd1);
        check("rd2_novalid", 64'(m_r_valid), 64'd0);
        s_ready = 4'b0100;
        tick();
        s_ready = '0;
        check("rd2_valid", 64'(m_r_valid), 64'd1);
        check("rd2_data",  64'(m_r_data),  64'hCCCC_0002);
        check("rd2_err",   64'(m_err),     64'd0);
        tick();
        check("rd2_idle",  64'(m_busy),    64'd0);
        check("rd2_vdrop", 64'(m_r_valid), 64'd0);
        check("rd2_hold",  64'(m_r_data),  64'hCCCC_0002);

        // Posted write 0xA5 to 0x404 hits slave 3 immediately.
        m_w_en = 1'b1; m_w_addr = 32'h404; m_w_data = 32'h0A5;
        #1 check("wr3_swen", 64'(s_w_en), 64'b1000);
        check("wr3_data", 64'(s_w_data), 64'h0A5);
        tick();
        m_w_en = 1'b0;
        check("wr3_noerr", 64'(m_err), 64'd0);
        check("wr3_cnt",   64'(err_cnt), 64'd0);

        // Slave 0 answering in the strobe cycle gives one-cycle latency.
        m_r_en = 1'b1; m_r_addr = 32'h010; s_ready = 4'b0001;
        #1 check("rd0_sren", 64'(s_r_en), 64'b0001);
        tick();
        m_r_en = 1'b0; s_ready = '0;
        check("rd0_valid", 64'(m_r_valid), 64'd1);
        check("rd0_data",  64'(m_r_data),  64'hAAAA_0000);
        tick();

        // Ready from other slaves is ignored while waiting on slave 1.
        m_r_en = 1'b1; m_r_addr = 32'h208;
        #1 check("rd1_sren", 64'(s_r_en), 64'b0010);
        tick();
        m_r_en = 1'b0; s_ready = 4'b1101;
        tick();
        check("rd1_ignore", 64'(m_r_valid), 64'd0);
        s_ready = 4'b0010;
        tick();
        s_ready = '0;
        check("rd1_valid", 64'(m_r_valid), 64'd1);
        check("rd1_data",  64'(m_r_data),  64'hBBBB_0001);
        tick();

        // Unmapped read 0x800.
        m_r_en = 1'b1; m_r_addr = 32'h800;
        #1 check("rdx_sren", 64'(s_r_en), 64'd0);
        tick();
        m_r_en = 1'b0;
        check("rdx_valid", 64'(m_r_valid), 64'd1);
        check("rdx_data",  64'(m_r_data),  64'd0);
        check("rdx_err",   64'(m_err),     64'd1);
        check("rdx_eaddr", 64'(err_addr),  64'h800);
        check("rdx_cnt",   64'(err_cnt),   64'd1);
        tick();
        check("rdx_errdrop", 64'(m_err), 64'd0);
        check("rdx_idle",    64'(m_busy), 64'd0);

        // Slave 1 never answers: abort 16 cycles after entering WAIT; a write slips through meanwhile.
        m_r_en = 1'b1; m_r_addr = 32'h200;
        tick();
        m_r_en = 1'b0;
        m_w_en = 1'b1; m_w_addr = 32'h300; m_w_data = 32'h55;
        #1 check("tmo_wr_swen", 64'(s_w_en), 64'b0100);
        n = 0;
        while (!m_r_valid && n < 40) begin
            tick();
            m_w_en = 1'b0;
            n++;
        end
        check("tmo_cycles", 64'(n), 64'd16);
        check("tmo_err",    64'(m_err),    64'd1);
        check("tmo_data",   64'(m_r_data), 64'd0);
        check("tmo_eaddr",  64'(err_addr), 64'h200);
        check("tmo_cnt",    64'(err_cnt),  64'd2);
        tick();
        check("tmo_idle", 64'(m_busy), 64'd0);

        // Reset in the third WAIT cycle abandons the read.
        m_r_en = 1'b1; m_r_addr = 32'h204;
        tick();
        m_r_en = 1'b0;
        tick();
        tick();
        rst = 1'b1; m_w_en = 1'b1; m_w_addr = 32'h404;
        #1 check("rst_swen_gate", 64'(s_w_en), 64'd0);
        tick();
        m_w_en = 1'b0;
        check("rstw_valid", 64'(m_r_valid), 64'd0);
        check("rstw_busy",  64'(m_busy),    64'd0);
        check("rstw_err",   64'(m_err),     64'd0);
        check("rstw_cnt",   64'(err_cnt),   64'd0);
        check("rstw_eaddr", 64'(err_addr),  64'd0);
        check("rstw_rdata", 64'(m_r_data),  64'd0);
        rst = 1'b0;
        m_r_en = 1'b1; m_r_addr = 32'h304; s_ready = 4'b0100;
        #1 check("rstw_newrd", 64'(s_r_en), 64'b0100);
        tick();
        m_r_en = 1'b0; s_ready = '0;
        check("rstw_newvalid", 64'(m_r_valid), 64'd1);
        check("rstw_newerr",   64'(m_err),     64'd0);
        tick();

        // Coincident read and write errors add two; read address wins.
        m_r_en = 1'b1; m_r_addr = 32'h900;
        m_w_en = 1'b1; m_w_addr = 32'h804;
        tick();
        m_r_en = 1'b0; m_w_en = 1'b0;
        check("dual_cnt",   64'(err_cnt),  64'd2);
        check("dual_eaddr", 64'(err_addr), 64'h900);
        check("dual_err",   64'(m_err),    64'd1);
        tick();

        // Flood of unmapped writes saturates the counter.
        exp_cnt = 2;
        for (int i = 0; i < 300; i++) begin
            m_w_en = 1'b1; m_w_addr = 32'h800 + 32'(i);
            if (i == 270) begin
                m_r_en = 1'b1; m_r_addr = 32'hA00;
            end
            tick();
            m_r_en = 1'b0;
            exp_cnt = exp_cnt + ((i == 270) ? 2 : 1);
            if (exp_cnt > 255) exp_cnt = 255;
            if (i == 200) check("sat_mid", 64'(err_cnt), 64'(exp_cnt));
        end
        m_w_en = 1'b0;
        check("sat_cnt", 64'(err_cnt), 64'd255);
        check("sat_eaddr", 64'(err_addr), 64'h800 + 64'd299);
        tick();
        check("sat_hold", 64'(err_cnt), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
